// File: rtl/mem_wb_stage_pkg.sv
// Shared types for the MEM/WB boundary: decoded instruction fields,
// load/store funct3 encodings and the writeback FSM state.
package mem_wb_stage_pkg;

  localparam logic [2:0] F3LS_B  = 3'b000;
  localparam logic [2:0] F3LS_H  = 3'b001;
  localparam logic [2:0] F3LS_W  = 3'b010;
  localparam logic [2:0] F3LS_D  = 3'b011;
  localparam logic [2:0] F3LS_BU = 3'b100;
  localparam logic [2:0] F3LS_HU = 3'b101;
  localparam logic [2:0] F3LS_WU = 3'b110;

  typedef struct packed {
    logic [2:0] funct3;
    logic       is_load;
    logic       is_store;
    logic       en_rd;
    logic [4:0] rd;
  } decoded_inst_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LOAD,
    WAIT_STORE
  } mem_wb_state_t;

endpackage

// File: rtl/mem_wb_stage_perf.sv
// Retirement / stall performance counters and a sticky memory-hang detector.
module wb_perf_counters #(
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 capture,
  input  logic                 stall,
  input  logic                 waiting,
  output logic [CNT_WIDTH-1:0] retired_count,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic                 mem_timeout
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  logic [WAIT_W-1:0] wait_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_count <= '0;
      stall_cycles  <= '0;
      wait_cnt      <= '0;
      mem_timeout   <= 1'b0;
    end else begin
      if (capture) retired_count <= retired_count + CNT_WIDTH'(1);
      if (stall)   stall_cycles  <= stall_cycles + CNT_WIDTH'(1);
      if (!waiting)
        wait_cnt <= '0;
      else if (wait_cnt != WAIT_W'(TIMEOUT))
        wait_cnt <= wait_cnt + WAIT_W'(1);
      // Flag on the same edge the counter reaches TIMEOUT.
      if (waiting && (wait_cnt >= WAIT_W'(TIMEOUT - 1)))
        mem_timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Writeback stage: waits for Dcache completion of loads/stores, stalls the
// pipeline meanwhile, and registers each completed instruction into MEM/WB.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  decoded_inst_t        inst,
  input  logic [XLEN-1:0]      ex_data,
  input  logic [XLEN-1:0]      mem_ex_rdata,
  input  logic                 is_bubble,
  input  logic                 dcache_en,
  input  logic                 dcache_valid,
  input  logic                 write_done,
  output logic                 mem_stall,
  output logic                 wb_en,
  output logic [4:0]           wb_rd,
  output logic [XLEN-1:0]      wb_data,
  output logic                 wb_retire,
  output logic [CNT_WIDTH-1:0] retired_count,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic                 mem_timeout
);

  mem_wb_state_t state, state_next;
  logic          mem_done;
  logic          capture;

  assign mem_done = inst.is_load ? dcache_valid : write_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (dcache_en) begin
          if (mem_done) capture = 1'b1;
          else          state_next = inst.is_load ? WAIT_LOAD : WAIT_STORE;
        end else if (!is_bubble) begin
          capture = 1'b1;
        end
      end
      WAIT_LOAD, WAIT_STORE: begin
        if (!dcache_en) begin
          state_next = IDLE;
        end else if (mem_done) begin
          capture    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_stall = reset && dcache_en && !mem_done;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_en     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      wb_retire <= 1'b0;
    end else begin
      wb_en     <= 1'b0;
      wb_retire <= 1'b0;
      if (capture) begin
        wb_rd     <= inst.rd;
        wb_data   <= inst.is_load ? mem_ex_rdata : ex_data;
        wb_en     <= inst.en_rd && (inst.rd != '0) && !inst.is_store;
        wb_retire <= 1'b1;
      end
    end
  end

  wb_perf_counters #(
    .CNT_WIDTH (CNT_WIDTH),
    .TIMEOUT   (TIMEOUT)
  ) u_perf (
    .clk           (clk),
    .reset         (reset),
    .capture       (capture),
    .stall         (mem_stall),
    .waiting       (state != IDLE),
    .retired_count (retired_count),
    .stall_cycles  (stall_cycles),
    .mem_timeout   (mem_timeout)
  );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed vectors push expected
// writebacks; a negedge monitor pops and compares on each wb_retire.
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  logic          clk;
  logic          reset;
  decoded_inst_t inst;
  logic [63:0]   ex_data;
  logic [63:0]   mem_ex_rdata;
  logic          is_bubble;
  logic          dcache_en;
  logic          dcache_valid;
  logic          write_done;
  logic          mem_stall;
  logic          wb_en;
  logic [4:0]    wb_rd;
  logic [63:0]   wb_data;
  logic          wb_retire;
  logic [31:0]   retired_count;
  logic [31:0]   stall_cycles;
  logic          mem_timeout;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    logic        en;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   stall_seen = 0;
  int   s0;

  mem_wb_stage #(
    .XLEN      (64),
    .CNT_WIDTH (32),
    .TIMEOUT   (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .inst          (inst),
    .ex_data       (ex_data),
    .mem_ex_rdata  (mem_ex_rdata),
    .is_bubble     (is_bubble),
    .dcache_en     (dcache_en),
    .dcache_valid  (dcache_valid),
    .write_done    (write_done),
    .mem_stall     (mem_stall),
    .wb_en         (wb_en),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .wb_retire     (wb_retire),
    .retired_count (retired_count),
    .stall_cycles  (stall_cycles),
    .mem_timeout   (mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit bub, input bit en, input bit ld, input bit st,
                        input bit enrd, input logic [4:0] rd,
                        input logic [63:0] ex, input logic [63:0] rdata);
    is_bubble     = bub;
    dcache_en     = en;
    dcache_valid  = 1'b0;
    write_done    = 1'b0;
    inst.funct3   = ld ? F3LS_D : F3LS_B;
    inst.is_load  = ld;
    inst.is_store = st;
    inst.en_rd    = enrd;
    inst.rd       = rd;
    ex_data       = ex;
    mem_ex_rdata  = rdata;
  endtask

  task automatic bubble();
    set_in(1, 0, 0, 0, 0, 5'd0, 64'h0, 64'h0);
  endtask

  task automatic push(input logic [4:0] rd, input logic [63:0] data, input logic en);
    exp_t e;
    e.rd = rd; e.data = data; e.en = en;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (mem_stall) stall_seen++;
      if (wb_retire) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_retire: got wb_rd=%0d wb_data=%0h expected no retire", wb_rd, wb_data);
        end else begin
          mon_e = sb.pop_front();
          chk("wb_rd", 64'(wb_rd), 64'(mon_e.rd));
          chk("wb_data", wb_data, mon_e.data);
          chk("wb_en", 64'(wb_en), 64'(mon_e.en));
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    set_in(0, 1, 1, 0, 1, 5'd4, 64'h0, 64'h0);
    #1;
    chk("rst_mem_stall", 64'(mem_stall), 64'h0);
    step(); step();
    chk("rst_wb_en", 64'(wb_en), 64'h0);
    chk("rst_wb_rd", 64'(wb_rd), 64'h0);
    chk("rst_wb_data", wb_data, 64'h0);
    chk("rst_wb_retire", 64'(wb_retire), 64'h0);
    chk("rst_retired", 64'(retired_count), 64'h0);
    chk("rst_stall_cycles", 64'(stall_cycles), 64'h0);
    chk("rst_timeout", 64'(mem_timeout), 64'h0);
    bubble();
    step();
    reset = 1'b1;
    step();

    // ALU op
    s0 = stall_seen;
    set_in(0, 0, 0, 0, 1, 5'd5, 64'h1234, 64'hDEAD);
    push(5'd5, 64'h1234, 1'b1);
    step();
    bubble();
    chk("alu_retired", 64'(retired_count), 64'd1);
    step();
    chk("alu_stall", 64'(stall_seen - s0), 64'd0);

    // Back-to-back load hits
    s0 = stall_seen;
    set_in(0, 1, 1, 0, 1, 5'd7, 64'hAAAA, 64'hFFFF_FFFF_FFFF_FF80);
    dcache_valid = 1'b1;
    push(5'd7, 64'hFFFF_FFFF_FFFF_FF80, 1'b1);
    step();
    set_in(0, 1, 1, 0, 1, 5'd8, 64'hBBBB, 64'h55);
    dcache_valid = 1'b1;
    push(5'd8, 64'h55, 1'b1);
    step();
    bubble();
    step();
    chk("hit_stall", 64'(stall_seen - s0), 64'd0);

    // Load miss: done 5 cycles after first presentation
    s0 = stall_seen;
    set_in(0, 1, 1, 0, 1, 5'd9, 64'h9000, 64'h42);
    repeat (5) step();
    dcache_valid = 1'b1;
    push(5'd9, 64'h42, 1'b1);
    step();
    bubble();
    step();
    chk("miss_stall", 64'(stall_seen - s0), 64'd5);

    // Store: done after 3 cycles, never writes the register file
    s0 = stall_seen;
    set_in(0, 1, 0, 1, 1, 5'd3, 64'h1000, 64'h0);
    repeat (3) step();
    write_done = 1'b1;
    push(5'd3, 64'h1000, 1'b0);
    step();
    bubble();
    step();
    chk("store_stall", 64'(stall_seen - s0), 64'd3);

    // Abandoned miss; stray dcache_valid while dcache_en low is ignored
    s0 = stall_seen;
    set_in(0, 1, 1, 0, 1, 5'd12, 64'h0, 64'h99);
    step(); step();
    bubble();
    dcache_valid = 1'b1;
    step();
    write_done = 1'b1;
    step();
    bubble();
    step();
    chk("abort_stall", 64'(stall_seen - s0), 64'd2);

    // Load to x0
    set_in(0, 1, 1, 0, 1, 5'd0, 64'h0, 64'h77);
    dcache_valid = 1'b1;
    push(5'd0, 64'h77, 1'b0);
    step();
    bubble();
    step();
    chk("retired_total", 64'(retired_count), 64'd6);
    chk("stall_cycles_total", 64'(stall_cycles), 64'd10);

    // Reset in the middle of a wait
    set_in(0, 1, 1, 0, 1, 5'd10, 64'h0, 64'h66);
    step(); step();
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_mem_stall", 64'(mem_stall), 64'h0);
    chk("midrst_wb_en", 64'(wb_en), 64'h0);
    chk("midrst_wb_rd", 64'(wb_rd), 64'h0);
    chk("midrst_wb_data", wb_data, 64'h0);
    chk("midrst_retire", 64'(wb_retire), 64'h0);
    chk("midrst_retired", 64'(retired_count), 64'h0);
    chk("midrst_stall_cycles", 64'(stall_cycles), 64'h0);
    bubble();
    step();
    reset = 1'b1;
    step(); step();
    set_in(0, 0, 0, 0, 1, 5'd1, 64'h5, 64'h0);
    push(5'd1, 64'h5, 1'b1);
    step();
    bubble();
    step();
    chk("postrst_retired", 64'(retired_count), 64'd1);

    // Hang detector with TIMEOUT = 8
    chk("timeout_pre", 64'(mem_timeout), 64'h0);
    set_in(0, 1, 1, 0, 1, 5'd11, 64'h0, 64'h0);
    repeat (8) step();
    chk("timeout_at_7", 64'(mem_timeout), 64'h0);
    step();
    chk("timeout_at_8", 64'(mem_timeout), 64'h1);
    bubble();
    repeat (3) step();
    chk("timeout_sticky", 64'(mem_timeout), 64'h1);

    repeat (3) step();
    chk("sb_drain", 64'(sb.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Writeback stage directly downstream of the memory stage. It tracks each load or store until the Dcache completes it, and holds the pipeline with `mem_stall` while it waits. Each completed instruction is registered into a one-entry MEM/WB latch that drives the register-file write port. The stage also keeps retirement and memory-stall performance counters, plus a sticky hang detector.

## Interface
- `XLEN`, 64: datapath width.
- `CNT_WIDTH`, 32: width of the performance counters.
- `TIMEOUT`, 1024: number of consecutive wait cycles on one memory op before `mem_timeout` is set.

Ports:
- `clk`, in, 1: single clock for the whole block.
- `reset`, in, 1: asynchronous, active-low; the block is in reset while this is 0.
- `inst`, in, `decoded_inst_t`: instruction currently in MEM.
- `ex_data`, in, XLEN: ALU result or address for the instruction in MEM.
- `mem_ex_rdata`, in, XLEN: sign/zero-extended load data from MEM.
- `is_bubble`, in, 1: the MEM slot is empty.
- `dcache_en`, in, 1: MEM holds a live load or store.
- `dcache_valid`, in, 1: load data is valid this cycle.
- `write_done`, in, 1: the store completed this cycle.
- `mem_stall`, out, 1: freezes IF through MEM.
- `wb_en`, out, 1: register-file write enable.
- `wb_rd`, out, 5: destination register.
- `wb_data`, out, XLEN: data to write.
- `wb_retire`, out, 1: one-cycle pulse per retired instruction.
- `retired_count`, out, CNT_WIDTH: total retired instructions.
- `stall_cycles`, out, CNT_WIDTH: total cycles with `mem_stall` high.
- `mem_timeout`, out, 1: sticky; a memory op exceeded `TIMEOUT`.

## Operation
- FSM states: `IDLE`, `WAIT_LOAD`, `WAIT_STORE`.
- "Done" means:
  - `dcache_valid` for a load;
  - `write_done` for a store;
  - always true for a non-memory op.
- In `IDLE`:
  - On a non-bubble non-memory instruction: capture it.
  - On `dcache_en` with done: capture it and stay in `IDLE`.
  - On `dcache_en` without done: go to `WAIT_LOAD` or `WAIT_STORE` (chosen by `inst.is_load`); no capture.
- In `WAIT_*`:
  - On done: capture and return to `IDLE`.
  - If `dcache_en` drops without done: return to `IDLE` with no capture and no retire.
- `mem_stall` is combinational: `dcache_en && !done`. It is therefore also high in the first cycle of a miss, and low in the cycle done is seen.
- Capture loads the MEM/WB latch on the clock edge:
  - `wb_rd` ← `inst.rd`;
  - `wb_data` ← `mem_ex_rdata` for a load, otherwise `ex_data`;
  - `wb_en` ← `inst.en_rd && inst.rd != 0 && !inst.is_store`;
  - `wb_retire` ← 1.
- In any cycle without a capture, the latch loads `wb_en = 0` and `wb_retire = 0`; `wb_rd` and `wb_data` hold their values.
- Counters:
  - `retired_count` increments on each capture.
  - `stall_cycles` increments on each cycle with `mem_stall` high.
  - Both wrap modulo 2^CNT_WIDTH.
- A wait counter clears in `IDLE` and increments each cycle in `WAIT_*`. When it reaches `TIMEOUT`, `mem_timeout` sets and stays set until reset. The wait counter saturates at `TIMEOUT`.

## Timing
- Reset values: FSM in `IDLE`; all outputs 0. Because `mem_stall` is combinational, it is gated to 0 while reset is asserted.
- Reset asserted mid-wait: the FSM goes to `IDLE` immediately (asynchronously) and the pending op is dropped, with no retire.
- Writeback latency: `wb_*` outputs are valid exactly 1 cycle after the capture cycle, for exactly 1 cycle.
- A hit load (done in its first MEM cycle) gives zero stall cycles and back-to-back throughput of 1 instruction per cycle.
- A miss that completes N cycles after first presentation produces N cycles of `mem_stall`. Capture happens in cycle N, counting the first presentation cycle as cycle 0.
- Simultaneous done and entry into wait is impossible: done in `IDLE` always captures directly.
- `dcache_valid` or `write_done` arriving while `dcache_en` is low is ignored.

## Structure
- The shared package holds:
  - `decoded_inst_t`, which must include the fields `is_load`, `is_store`, `rd[4:0]` and `en_rd`;
  - the `F3LS_*` constants;
  - the new enum `mem_wb_state_t` (`IDLE`, `WAIT_LOAD`, `WAIT_STORE`).
- One natural sub-module: `wb_perf_counters`, which contains the two wrapping counters, the wait counter and the sticky timeout.

## Test plan
- ALU op: `rd = 5`, `ex_data = 0x1234`, not a bubble → next cycle `wb_en = 1`, `wb_rd = 5`, `wb_data = 0x1234`, `wb_retire` is a 1-cycle pulse, `retired_count = 1`; `mem_stall` never goes high.
- Load hit: `dcache_valid` high in the first cycle, `mem_ex_rdata = 0xFFFF_FFFF_FFFF_FF80`, `rd = 7` → zero stall cycles; writes back `0xFFFF_FFFF_FFFF_FF80` to x7.
- Load miss: `dcache_valid` arrives 5 cycles later → `mem_stall` high for 5 cycles, `stall_cycles = 5`, a single writeback in the following cycle.
- Store: `write_done` after 3 cycles → 3 stall cycles, `wb_retire = 1`, `wb_en = 0`.
- Load with `rd = 0` → `wb_en = 0`, `wb_retire = 1`.
- Reset pulled low during `WAIT_LOAD`, then released → all outputs 0, FSM in `IDLE`, no writeback. Separately: a load never completing with `TIMEOUT = 8` → `mem_timeout` goes high after 8 wait cycles and stays high.
